watchdog_monitor: RTL and testbench
===================================

WATCHDOG_MONITOR -- requirements
Module: watchdog

Interface
REQ-001 Parameter IAGC_STATUS_SIZE, default 4, SHALL set the width of the IAGC status bus.
REQ-002 Parameter TICKS, default 10, SHALL set the timeout length in clock cycles (legal range >= 2).
REQ-003 i_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 i_iagcStatus  input  IAGC_STATUS_SIZE  SHALL be the IAGC system status; RESET=0, INIT=1, IDLE=2, any other value = operational.
REQ-006 i_gate  input  1  SHALL be the monitored heartbeat; only its rising edge is significant.
REQ-007 o_valid  output  1  SHALL be registered; 1 = a heartbeat was seen within the last TICKS cycles while armed.

Function
REQ-008 The watchdog SHALL be "armed" when i_iagcStatus is neither RESET (0) nor INIT (1).
REQ-009 A rising edge SHALL be detected as i_gate=1 this cycle with the registered previous i_gate=0; a level held high SHALL count as one edge only.
REQ-010 A 3-state FSM SHALL be used: DISARMED, RUNNING, EXPIRED.
REQ-011 Cycle counter width SHALL be clog2(TICKS+1) bits and SHALL never wrap.
REQ-012 In any state, if not armed: next state DISARMED, counter 0; this takes priority over a simultaneous gate edge.
REQ-013 DISARMED and armed: next state RUNNING, counter 0, regardless of i_gate.
REQ-014 RUNNING, armed, gate edge: stay RUNNING, counter 0.
REQ-015 RUNNING, armed, no edge, counter < TICKS-1: counter +1.
REQ-016 RUNNING, armed, no edge, counter = TICKS-1: next state EXPIRED, counter held.
REQ-017 EXPIRED, armed, gate edge: next state RUNNING, counter 0; otherwise stay EXPIRED.
REQ-018 o_valid SHALL equal (state == RUNNING), decoded from the state register, with no combinational path from inputs.
REQ-019 Consequently, after arming or after a gate edge, o_valid SHALL stay 1 for exactly TICKS cycles unless a further edge restarts the count.
REQ-020 An edge arriving in the last RUNNING cycle (counter = TICKS-1) SHALL restart the count; o_valid SHALL not drop.
REQ-021 A status change between operational values (e.g. IDLE to another operational value) SHALL NOT restart or clear the count.

Reset
REQ-022 With i_reset_n=0 at a rising edge of i_clock: state DISARMED, counter 0, previous-gate register 0, o_valid 0.
REQ-023 Reset SHALL override every other condition, including in mid-count; after release the FSM SHALL follow REQ-012/013 on the next edge.

Structure
REQ-024 A shared package SHALL hold the status encodings (RESET, INIT, IDLE), IAGC_STATUS_SIZE default and the FSM state typedef/encoding.
REQ-025 Rising-edge detection SHALL be a sub-module, rise_detect (clock, reset, input, pulse output), reusable elsewhere.
REQ-026 The top level SHALL contain only the FSM, the counter and the output register.

Verification (TICKS=10, 10 ns clock)
REQ-027 Reset asserted, status RESET for 10 cycles, then INIT for 10 cycles -> o_valid 0 throughout.
REQ-028 Status to IDLE, no gate -> o_valid 1 from the next edge for exactly 10 cycles, then 0 and stays 0.
REQ-029 In EXPIRED, i_gate high for 2 cycles -> o_valid 1 for exactly 10 cycles after the edge, then 0; the held-high level gives no second restart.
REQ-030 In RUNNING, pulse i_gate every 9 cycles -> o_valid never drops; pulse every 11 cycles -> o_valid drops for 1 cycle each period.
REQ-031 In RUNNING, status to INIT at the same time as a gate edge -> o_valid 0 next cycle and counter 0.
REQ-032 i_reset_n=0 for 1 cycle in mid-RUNNING with status IDLE -> o_valid 0 for one cycle, then a fresh 10-cycle RUNNING window.

Source files
------------

// File: rtl/watchdog_monitor_pkg.sv
// Shared definitions for the IAGC heartbeat watchdog: status encodings,
// default bus width and the FSM state type.
package watchdog_monitor_pkg;

    localparam int IAGC_STATUS_SIZE_DEFAULT = 4;

    // IAGC status codes; every other value is treated as operational
    localparam int unsigned STATUS_RESET = 0;
    localparam int unsigned STATUS_INIT  = 1;
    localparam int unsigned STATUS_IDLE  = 2;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_EXPIRED  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/watchdog_monitor_rise_detect.sv
// Generic rising-edge detector: a one-cycle pulse when the input is high
// now and was low on the previous clock. A held-high level gives one pulse.
module rise_detect (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_din,
    output logic o_pulse
);

    logic prev_q;
    logic prev_d;

    // Next value of the history register is simply the current input
    always_comb begin
        prev_d = i_din;
    end

    // History register, cleared by synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_pulse = i_din & ~prev_q;

endmodule

// File: rtl/watchdog_monitor.sv
// Heartbeat watchdog for the IAGC system. While the system is armed (status
// neither RESET nor INIT) o_valid stays high for TICKS cycles after arming or
// after each rising edge of i_gate, and drops if no heartbeat arrives in time.
module watchdog_monitor
    import watchdog_monitor_pkg::*;
#(
    parameter int IAGC_STATUS_SIZE = IAGC_STATUS_SIZE_DEFAULT,
    parameter int TICKS            = 10
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagcStatus,
    input  logic                        i_gate,
    output logic                        o_valid
);

    localparam int CNT_W = $clog2(TICKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS - 1);

    wd_state_e        state_q;
    wd_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;
    logic             valid_d;
    logic             gate_edge;
    logic             armed;

    rise_detect u_rise_detect (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_din     (i_gate),
        .o_pulse   (gate_edge)
    );

    // Armed whenever the IAGC system is past its RESET/INIT phases
    always_comb begin
        armed = (i_iagcStatus != IAGC_STATUS_SIZE'(STATUS_RESET)) &&
                (i_iagcStatus != IAGC_STATUS_SIZE'(STATUS_INIT));
    end

    // Next-state and counter logic; disarming beats any simultaneous edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!armed) begin
            state_d = ST_DISARMED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    state_d = ST_RUNNING;
                    cnt_d   = '0;
                end
                ST_RUNNING: begin
                    if (gate_edge) begin
                        cnt_d = '0;
                    end else if (cnt_q < LAST_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_EXPIRED;
                    end
                end
                ST_EXPIRED: begin
                    if (gate_edge) begin
                        state_d = ST_RUNNING;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register always tracks "state is RUNNING" in step with the FSM
    always_comb begin
        valid_d = (state_d == ST_RUNNING);
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= ST_DISARMED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;

endmodule

// File: tb/tb_watchdog_monitor.sv
// Directed bench for watchdog_monitor. A behavioural "remaining window"
// model predicts o_valid for every stimulus cycle; predictions are queued
// and compared just after the clock edge that produces them.
module tb_watchdog_monitor;
    import watchdog_monitor_pkg::*;

    localparam int TICKS = 10;
    localparam int SW    = 4;

    logic          i_clock;
    logic          i_reset_n;
    logic [SW-1:0] i_iagcStatus;
    logic          i_gate;
    logic          o_valid;

    typedef struct {
        string tag;
        logic  exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int tests_run;
    int tests_failed;

    int   m_rem;
    bit   m_disarmed;
    logic m_prev;

    watchdog_monitor #(
        .IAGC_STATUS_SIZE (SW),
        .TICKS            (TICKS)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_iagcStatus (i_iagcStatus),
        .i_gate       (i_gate),
        .o_valid      (o_valid)
    );

    // Free-running 10 ns clock
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Pop the oldest prediction and compare it with o_valid
    task automatic checkOutput();
        sb_entry_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty: o_valid=%0b with no expected value", o_valid);
        end else begin
            e = sb_q.pop_front();
            assert (o_valid === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: o_valid=%0b expected %0b", e.tag, o_valid, e.exp);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic applyStimulus(input logic rst_n, input logic [SW-1:0] status,
                                 input logic gate, input string tag);
        logic edge_seen;
        sb_entry_t e;
        i_reset_n    = rst_n;
        i_iagcStatus = status;
        i_gate       = gate;
        edge_seen    = gate && !m_prev;
        if (!rst_n) begin
            m_disarmed = 1'b1;
            m_rem      = 0;
            m_prev     = 1'b0;
        end else begin
            m_prev = gate;
            if (status == SW'(STATUS_RESET) || status == SW'(STATUS_INIT)) begin
                m_disarmed = 1'b1;
                m_rem      = 0;
            end else if (m_disarmed) begin
                m_disarmed = 1'b0;
                m_rem      = TICKS;
            end else if (edge_seen) begin
                m_rem = TICKS;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
        e.tag = tag;
        e.exp = (m_rem > 0);
        sb_q.push_back(e);
        @(posedge i_clock);
        #1;
        checkOutput();
    endtask

    // Linear sequence of directed steps
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_rem        = 0;
        m_disarmed   = 1'b1;
        m_prev       = 1'b0;
        i_reset_n    = 1'b0;
        i_iagcStatus = '0;
        i_gate       = 1'b0;
        @(negedge i_clock);

        // Reset, then RESET and INIT status: never valid
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'd0, 1'b0, "reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'd0, 1'b0, "status_reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'd1, (i == 4), "status_init");

        // Arm with IDLE, no heartbeat: 10-cycle window then expire
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 4'd2, 1'b0, "arm_window");

        // Gate held high two cycles while expired: one restart only
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 4'd2, 1'b1, "held_gate");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'd2, 1'b0, "held_gate_tail");

        // Heartbeat every 9 cycles, status wandering between operational codes
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 9; i++)
                applyStimulus(1'b1, (p[0] ? 4'd7 : 4'd2), (i == 0), "period9");
        end

        // Heartbeat every 10 cycles: edge lands in the last running cycle
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++)
                applyStimulus(1'b1, 4'd5, (i == 0), "period10");
        end

        // Heartbeat every 11 cycles: one expired cycle per period
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 11; i++)
                applyStimulus(1'b1, 4'd2, (i == 0), "period11");
        end

        // Running, then INIT together with a gate edge: disarm wins
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd2, 1'b0, "pre_disarm");
        applyStimulus(1'b1, 4'd1, 1'b1, "disarm_vs_edge");
        tests_run++;
        assert (dut.cnt_q === '0) else begin
            tests_failed++;
            $error("FAIL disarm_cnt: cnt_q=%0d expected 0", dut.cnt_q);
        end
        applyStimulus(1'b1, 4'd1, 1'b0, "disarm_hold");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'd2, 1'b0, "rearm_window");

        // One-cycle reset in mid-run gives a fresh window afterwards
        applyStimulus(1'b1, 4'd2, 1'b1, "pre_reset_edge");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd2, 1'b0, "pre_reset_run");
        applyStimulus(1'b0, 4'd2, 1'b0, "mid_reset");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'd2, 1'b0, "post_reset_window");

        tests_run++;
        assert (sb_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_leftover: entries=%0d expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
